// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
package ifu_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;
    localparam int          INST_W       = 32;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/ifu_queue.sv
// DEPTH-entry FIFO of {pc, instruction} pairs with a single-cycle flush.
module ifu_queue
    import ifu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      push,
    input  logic [31:0]               push_pc,
    input  logic [INST_W-1:0]         push_inst,
    input  logic                      pop,
    output logic [$clog2(DEPTH):0]    count,
    output logic [31:0]               head_pc,
    output logic [INST_W-1:0]         head_inst
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]       pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // Push into a full queue is only ever paired with a pop, so the write may reuse the head slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]   <= push_pc;
                inst_mem[wr_ptr] <= push_inst;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_pc   = pc_mem[rd_ptr];
    assign head_inst = inst_mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues word fetches, tracks in-flight/discarded responses, queues instructions.
// Optional performance counters are built when the macro IFU_PERF_EN is defined.
module instruction_fetch_unit
    import ifu_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              halt_req,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [31:0]       mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [INST_W-1:0] mem_resp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_pc,
    output logic [INST_W-1:0] inst
`ifdef IFU_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_drop_cnt
`endif
);

    localparam int                CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0]    DEPTH_V = (CNT_W + 1)'(DEPTH);

    state_t            state;
    state_t            next_state;
    logic [31:0]       fetch_pc;
    logic [31:0]       resp_pc;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  discard;
    logic [CNT_W-1:0]  occupancy;
    logic              redirect;
    logic              req_fire;
    logic              resp_fire;
    logic              push;
    logic              drop;
    logic              pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  next_state = S_FETCH;
            S_FETCH: if (halt_req) next_state = S_HALT;
            S_HALT:  next_state = S_HALT;
            default: next_state = S_IDLE;
        endcase
    end

    // Occupancy plus in-flight is a credit count, so a response always has a queue slot.
    always_comb begin
        redirect      = redirect_valid && (state != S_HALT);
        mem_req_valid = (state == S_FETCH) && !redirect_valid &&
                        (({1'b0, occupancy} + {1'b0, inflight}) < DEPTH_V);
        mem_req_addr  = fetch_pc;
    end

    assign req_fire   = mem_req_valid && mem_req_ready;
    assign resp_fire  = mem_resp_valid && (inflight != '0);
    assign push       = resp_fire && !redirect && (discard == '0);
    assign drop       = resp_fire && (redirect || (discard != '0));
    assign inst_valid = (occupancy != '0);
    assign pop        = inst_valid && inst_ready && !redirect;

    // resp_pc names the next kept response; after a redirect that is the redirect target itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
        end else begin
            inflight <= inflight + CNT_W'(req_fire) - CNT_W'(resp_fire);
            if (redirect) begin
                fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
                resp_pc  <= redirect_pc & 32'hFFFF_FFFC;
                discard  <= inflight - CNT_W'(resp_fire);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + 32'd4;
                if (push)     resp_pc  <= resp_pc + 32'd4;
                if (drop)     discard  <= discard - CNT_W'(1);
            end
        end
    end

    ifu_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (push),
        .push_pc   (resp_pc),
        .push_inst (mem_resp_data),
        .pop       (pop),
        .count     (occupancy),
        .head_pc   (inst_pc),
        .head_inst (inst)
    );

`ifdef IFU_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetch_cnt <= '0;
            perf_drop_cnt  <= '0;
        end else begin
            if (pop)  perf_fetch_cnt <= sat_inc(perf_fetch_cnt);
            if (drop) perf_drop_cnt  <= sat_inc(perf_drop_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_instruction_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt_req = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_pc;
    logic [31:0] inst;
`ifdef IFU_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_drop_cnt;
`endif

    instruction_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_pc        (inst_pc),
        .inst           (inst)
`ifdef IFU_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_drop_cnt  (perf_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] data; } entry_t;
    typedef struct { logic [31:0] pc; bit stale; } req_t;
    typedef struct { logic [31:0] data; int due; } mem_t;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          lat_lo = 0;
    int          lat_hi = 0;
    bit          resp_rand = 1'b0;

    // Reference model: delivered-instruction queue, outstanding-request list, fetch address, phase.
    entry_t      mq[$];
    req_t        mo[$];
    mem_t        mem_q[$];
    int          phase = 0;
    logic [31:0] m_fetch_pc = RESET_PC;
    int          fetch_cnt = 0;
    int          drop_cnt = 0;

    bit          exp_req_valid;
    logic [31:0] exp_req_addr;
    bit          exp_inst_valid;
    logic [31:0] exp_inst_pc;
    logic [31:0] exp_inst;
    bit          dut_acc;

    task automatic drive(input bit rv, input logic [31:0] rpc, input bit hq, input bit rdy, input bit ir);
        @(negedge clk);
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt_req       = hq;
        mem_req_ready  = rdy;
        inst_ready     = ir;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc && (!resp_rand || $urandom_range(0, 3) != 0)) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_q[0].data;
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = $urandom;
        end
        exp_req_valid  = (phase == 1) && (mq.size() + mo.size() < DEPTH) && !rv;
        exp_req_addr   = m_fetch_pc;
        exp_inst_valid = (mq.size() != 0);
        exp_inst_pc    = exp_inst_valid ? mq[0].pc : 32'h0;
        exp_inst       = exp_inst_valid ? mq[0].data : 32'h0;
        #1;
        dut_acc = mem_req_valid && mem_req_ready;
    endtask

    task automatic commit();
        bit     acc;
        bit     resp;
        bit     redir;
        bit     popv;
        req_t   r;
        entry_t e;
        mem_t   m;
        acc   = exp_req_valid && mem_req_ready;
        resp  = mem_resp_valid && (mo.size() != 0);
        redir = redirect_valid && (phase != 2);
        popv  = exp_inst_valid && inst_ready && !redir;
        if (mem_resp_valid && mem_q.size() != 0) mem_q.delete(0);
        if (dut_acc) begin
            m.data = $urandom;
            m.due  = cyc + 1 + int'($urandom_range(lat_hi, lat_lo));
            mem_q.push_back(m);
        end
        if (popv) begin
            mq.delete(0);
            fetch_cnt++;
        end
        if (resp) begin
            r = mo[0];
            mo.delete(0);
            if (r.stale || redir) begin
                drop_cnt++;
            end else begin
                e.pc   = r.pc;
                e.data = mem_resp_data;
                mq.push_back(e);
            end
        end
        if (redir) begin
            foreach (mo[i]) mo[i].stale = 1'b1;
            mq.delete();
            m_fetch_pc = {redirect_pc[31:2], 2'b00};
        end
        if (acc) begin
            r.pc    = m_fetch_pc;
            r.stale = 1'b0;
            mo.push_back(r);
            m_fetch_pc = m_fetch_pc + 32'd4;
        end
        if (phase == 0) phase = 1;
        else if (phase == 1 && halt_req) phase = 2;
        @(posedge clk);
        cyc++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset          = 1'b0;
        redirect_valid = 1'b0;
        halt_req       = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        inst_ready     = 1'b0;
        resp_rand      = 1'b0;
        mem_q.delete();
        mo.delete();
        mq.delete();
        phase      = 0;
        m_fetch_pc = RESET_PC;
        fetch_cnt  = 0;
        drop_cnt   = 0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({mem_req_valid, inst_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_valids: got %b required 00", {mem_req_valid, inst_valid});
        end
        n_checks++;
        if ({inst, inst_pc} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_head: got inst=%h pc=%h required 0/0", inst, inst_pc);
        end
`ifdef IFU_PERF_EN
        n_checks++;
        if ({perf_fetch_cnt, perf_drop_cnt} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_perf: got %h/%h required 0/0", perf_fetch_cnt, perf_drop_cnt);
        end
`endif
        apply_reset();
        drive(0, 0, 0, 1, 1);
        n_checks++;
        if (mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_req: got %b required 0", mem_req_valid);
        end
        commit();
    endtask

    task automatic test_basic_stream();
        logic [31:0] addrs[$];
        apply_reset();
        lat_lo = 0;
        lat_hi = 0;
        for (int c = 0; c < 12; c++) begin
            drive(0, 0, 0, 1, 1);
            if (dut_acc) addrs.push_back(mem_req_addr);
            if (c == 1) begin
                n_checks++;
                if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h0}) begin
                    n_fail++;
                    $display("FAIL first_req: got v=%b a=%h required 1/00000000", mem_req_valid, mem_req_addr);
                end
            end
            if (c == 2) begin
                n_checks++;
                if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h4}) begin
                    n_fail++;
                    $display("FAIL second_req: got v=%b a=%h required 1/00000004", mem_req_valid, mem_req_addr);
                end
            end
            if (c == 3) begin
                n_checks++;
                if ({inst_valid, inst_pc} !== {1'b1, 32'h0}) begin
                    n_fail++;
                    $display("FAIL first_inst: got v=%b pc=%h required 1/00000000", inst_valid, inst_pc);
                end
            end
            commit();
        end
        n_checks++;
        if (addrs.size() < 3) begin
            n_fail++;
            $display("FAIL stream_count: got %0d required at least 3", addrs.size());
        end else if ({addrs[0], addrs[1], addrs[2]} !== {32'h0, 32'h4, 32'h8}) begin
            n_fail++;
            $display("FAIL stream_addrs: got %h %h %h required 0 4 8", addrs[0], addrs[1], addrs[2]);
        end
    endtask

    task automatic test_queue_full();
        int          n_acc;
        logic [31:0] a;
        apply_reset();
        lat_lo = 0;
        lat_hi = 0;
        n_acc  = 0;
        a      = 32'hFFFF_FFFF;
        for (int c = 0; c < 8; c++) begin
            drive(0, 0, 0, 1, 0);
            n_acc += int'(dut_acc);
            commit();
        end
        n_checks++;
        if (n_acc !== 2) begin
            n_fail++;
            $display("FAIL full_accepts: got %0d required 2", n_acc);
        end
        drive(0, 0, 0, 1, 1);
        n_checks++;
        if ({mem_req_valid, inst_valid, inst_pc} !== {2'b01, 32'h0}) begin
            n_fail++;
            $display("FAIL full_state: got req=%b iv=%b pc=%h required 0/1/0", mem_req_valid, inst_valid, inst_pc);
        end
        commit();
        n_acc = 0;
        for (int c = 0; c < 6; c++) begin
            drive(0, 0, 0, 1, 0);
            if (dut_acc) begin
                n_acc++;
                a = mem_req_addr;
            end
            commit();
        end
        n_checks++;
        if ({n_acc, a} !== {32'd1, 32'h8}) begin
            n_fail++;
            $display("FAIL refill: got %0d accepts last=%h required 1 at 00000008", n_acc, a);
        end
    endtask

    task automatic test_redirect();
        int          n_acc;
        logic [31:0] first_addr;
        logic [31:0] first_pc;
        bit          got_addr;
        bit          got_pc;
        apply_reset();
        lat_lo = 3;
        lat_hi = 3;
        n_acc  = 0;
        for (int c = 0; c < 6 && n_acc < 2; c++) begin
            drive(0, 0, 0, 1, 1);
            n_acc += int'(dut_acc);
            commit();
        end
        n_checks++;
        if (n_acc !== 2) begin
            n_fail++;
            $display("FAIL redir_setup: got %0d accepts required 2", n_acc);
        end
        drive(1, 32'h103, 0, 1, 1);
        n_checks++;
        if (mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_suppress: got %b required 0", mem_req_valid);
        end
        commit();
        got_addr   = 0;
        got_pc     = 0;
        first_addr = 32'hFFFF_FFFF;
        first_pc   = 32'hFFFF_FFFF;
        for (int c = 0; c < 20; c++) begin
            drive(0, 0, 0, 1, 1);
            if (dut_acc && !got_addr) begin
                got_addr   = 1;
                first_addr = mem_req_addr;
            end
            if (inst_valid && !got_pc) begin
                got_pc   = 1;
                first_pc = inst_pc;
            end
            commit();
        end
        n_checks++;
        if (first_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL redir_addr: got %h required 00000100", first_addr);
        end
        n_checks++;
        if (first_pc !== 32'h100) begin
            n_fail++;
            $display("FAIL redir_first_pc: got %h required 00000100", first_pc);
        end
`ifdef IFU_PERF_EN
        n_checks++;
        if (perf_drop_cnt !== 32'd2) begin
            n_fail++;
            $display("FAIL redir_drop_cnt: got %0d required 2", perf_drop_cnt);
        end
`endif
    endtask

    task automatic test_ready_stall();
        int n_acc;
        int n_valid;
        int n8;
        apply_reset();
        lat_lo = 0;
        lat_hi = 0;
        n_acc  = 0;
        for (int c = 0; c < 6 && n_acc < 2; c++) begin
            drive(0, 0, 0, 1, 1);
            n_acc += int'(dut_acc);
            commit();
        end
        n_valid = 0;
        for (int c = 0; c < 5; c++) begin
            drive(0, 0, 0, 0, 1);
            if (mem_req_valid) begin
                n_valid++;
                n_checks++;
                if (mem_req_addr !== 32'h8) begin
                    n_fail++;
                    $display("FAIL stall_addr: got %h required 00000008", mem_req_addr);
                end
            end
            commit();
        end
        n_checks++;
        if (n_valid !== 4) begin
            n_fail++;
            $display("FAIL stall_valid_cycles: got %0d required 4", n_valid);
        end
        n8 = 0;
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 0, 1, 1);
            if (dut_acc && mem_req_addr == 32'h8) n8++;
            commit();
        end
        n_checks++;
        if (n8 !== 1) begin
            n_fail++;
            $display("FAIL stall_accepts: got %0d required 1", n8);
        end
    endtask

    task automatic test_halt();
        int          n_del;
        logic [31:0] del_pc;
        apply_reset();
        lat_lo = 1;
        lat_hi = 1;
        drive(0, 0, 0, 1, 1);
        commit();
        drive(0, 0, 0, 1, 1);
        n_checks++;
        if (dut_acc !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_setup: got %b required 1", dut_acc);
        end
        commit();
        drive(0, 0, 1, 0, 1);
        commit();
        n_del  = 0;
        del_pc = 32'hFFFF_FFFF;
        for (int c = 0; c < 10; c++) begin
            drive(c == 0, 32'h40, 0, 1, 1);
            n_checks++;
            if (mem_req_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_no_req: got %b required 0 (cycle %0d)", mem_req_valid, c);
            end
            if (inst_valid) begin
                n_del++;
                del_pc = inst_pc;
            end
            commit();
        end
        n_checks++;
        if ({n_del, del_pc} !== {32'd1, 32'h0}) begin
            n_fail++;
            $display("FAIL halt_delivery: got %0d pops last pc=%h required 1 at 00000000", n_del, del_pc);
        end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        lat_lo = 0;
        lat_hi = 0;
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 0, 1, 0);
            commit();
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (inst_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_setup: got inst_valid=%b required 1", inst_valid);
        end
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if ({mem_req_valid, inst_valid, inst, inst_pc} !== {2'b00, 64'h0}) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got req=%b iv=%b inst=%h pc=%h required all 0",
                     mem_req_valid, inst_valid, inst, inst_pc);
        end
        apply_reset();
        drive(0, 0, 0, 1, 1);
        commit();
        drive(0, 0, 0, 1, 1);
        n_checks++;
        if ({mem_req_valid, mem_req_addr} !== {1'b1, RESET_PC}) begin
            n_fail++;
            $display("FAIL mid_restart: got v=%b a=%h required 1/%h", mem_req_valid, mem_req_addr, RESET_PC);
        end
        commit();
    endtask

    task automatic test_random();
        apply_reset();
        lat_lo    = 0;
        lat_hi    = 3;
        resp_rand = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            drive($urandom_range(0, 15) == 0, $urandom, c == 1400,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
            n_checks++;
            if (mem_req_valid !== exp_req_valid) begin
                n_fail++;
                $display("FAIL rnd_req_valid: cycle %0d got %b required %b", c, mem_req_valid, exp_req_valid);
            end
            if (exp_req_valid) begin
                n_checks++;
                if (mem_req_addr !== exp_req_addr) begin
                    n_fail++;
                    $display("FAIL rnd_req_addr: cycle %0d got %h required %h", c, mem_req_addr, exp_req_addr);
                end
            end
            n_checks++;
            if (inst_valid !== exp_inst_valid) begin
                n_fail++;
                $display("FAIL rnd_inst_valid: cycle %0d got %b required %b", c, inst_valid, exp_inst_valid);
            end
            if (exp_inst_valid) begin
                n_checks++;
                if ({inst_pc, inst} !== {exp_inst_pc, exp_inst}) begin
                    n_fail++;
                    $display("FAIL rnd_head: cycle %0d got pc=%h inst=%h required pc=%h inst=%h",
                             c, inst_pc, inst, exp_inst_pc, exp_inst);
                end
            end
`ifdef IFU_PERF_EN
            n_checks++;
            if ({perf_fetch_cnt, perf_drop_cnt} !== {32'(fetch_cnt), 32'(drop_cnt)}) begin
                n_fail++;
                $display("FAIL rnd_perf: cycle %0d got %0d/%0d required %0d/%0d",
                         c, perf_fetch_cnt, perf_drop_cnt, fetch_cnt, drop_cnt);
            end
`endif
            commit();
        end
    endtask

    initial begin
        $display("[TB] instruction_fetch_unit bench start");
        test_reset();
        test_basic_stream();
        test_queue_full();
        test_redirect();
        test_ready_stall();
        test_halt();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter DEPTH, default 2, sets the instruction queue entries and the maximum in-flight fetch count (power of two, 2..8).
REQ-002 Parameter RESET_PC, default 32'h0, sets the fetch address after reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 redirect_valid  input  1  the core's next_pc differs from sequential; restart fetch.
REQ-006 redirect_pc  input  32  new fetch address; bits [1:0] ignored (treated as 0).
REQ-007 halt_req  input  1  core halted (ecall); stop issuing fetches.
REQ-008 mem_req_valid  output  1  fetch request valid.
REQ-009 mem_req_ready  input  1  memory accepts request.
REQ-010 mem_req_addr  output  32  word-aligned fetch address.
REQ-011 mem_resp_valid  input  1  in-order response for the oldest accepted request; never in the cycle of acceptance.
REQ-012 mem_resp_data  input  32  fetched instruction word.
REQ-013 inst_valid  output  1  queue head holds an instruction for the core.
REQ-014 inst_ready  input  1  core consumes the head.
REQ-015 inst_pc  output  32  address of the head instruction.
REQ-016 inst  output  32  head instruction word.
REQ-017 perf_fetch_cnt / perf_drop_cnt  output  32 each  delivered / discarded response counts (present only under IFU_PERF_EN).

Function
REQ-018 FSM states: S_IDLE (first cycle after reset, no request), S_FETCH, S_HALT; S_IDLE->S_FETCH unconditionally; S_FETCH->S_HALT on halt_req; S_HALT is left only by reset.
REQ-019 In S_FETCH, mem_req_valid = (queue occupancy + in-flight count < DEPTH) and no redirect_valid this cycle.
REQ-020 A request handshake (valid & ready) increments in-flight count and advances fetch_pc by 4, wrapping modulo 2^32.
REQ-021 mem_req_valid and mem_req_addr stay stable until accepted unless redirect_valid or halt_req is asserted.
REQ-022 A response with discard count zero is pushed into the queue with its pc; in-flight decrements.
REQ-023 redirect_valid: fetch_pc <= {redirect_pc[31:2],2'b00}; queue flushed; discard count <= in-flight count, excluding any request accepted the same cycle (suppressed by REQ-019); subsequent responses decrement discard and are dropped.
REQ-024 Response arriving in the redirect cycle belongs to the old stream and is dropped.
REQ-025 Queue push and pop in the same cycle are legal at any occupancy, including full; occupancy + in-flight never exceeds DEPTH.
REQ-026 inst_valid = occupancy != 0; inst/inst_pc are the registered head entry; a pop occurs on inst_valid & inst_ready; pointers wrap modulo DEPTH.
REQ-027 Redirect and pop in the same cycle: flush wins, no pop is counted as delivered.
REQ-028 In S_HALT: mem_req_valid = 0; redirect_valid ignored; outstanding responses still enqueued and deliverable.
REQ-029 Minimum latency: request accepted cycle N, response N+1, inst_valid N+2.

Reset
REQ-030 Reset asserted (low) at any time, including mid-transaction: state S_IDLE, fetch_pc = RESET_PC, queue empty, in-flight = discard = 0, mem_req_valid = 0, inst_valid = 0, inst = 0, inst_pc = 0, perf counters = 0.
REQ-031 Responses for requests issued before reset are the memory's responsibility; the unit ignores mem_resp_valid while in-flight = 0.

Configuration
REQ-032 Macro IFU_PERF_EN defined: perf counters present, increment per delivered pop and per discarded response, saturate at 32'hFFFF_FFFF.
REQ-033 Macro IFU_PERF_EN undefined: perf ports and counter logic absent; all other behaviour identical.

Structure
REQ-034 Shared package ifu_pkg holds the FSM state enum, RESET_PC default, and the instruction-word width constant.
REQ-035 One sub-module, ifu_queue (DEPTH-entry synchronous FIFO of {pc, inst}, with flush), is instantiated; the rest is in the top module.

Verification
REQ-036 Reset, mem always ready, 1-cycle latency, inst_ready=1 -> requests 0x0,0x4,0x8 on consecutive cycles after S_IDLE; first inst_valid two cycles after first request with inst_pc=0x0.
REQ-037 inst_ready=0, DEPTH=2 -> exactly two requests accepted, queue full, mem_req_valid=0 until one pop, then one request issued.
REQ-038 Two requests in flight, redirect_pc=0x103 -> both responses dropped, next request addr 0x100, first delivered inst_pc=0x100, perf_drop_cnt=2 (with IFU_PERF_EN).
REQ-039 mem_req_ready low 5 cycles -> mem_req_addr held constant at 0x8, single acceptance when ready rises.
REQ-040 halt_req with one request in flight -> no further requests, in-flight response delivered, subsequent redirect to 0x40 ignored.
REQ-041 reset pulsed low mid-stream with occupancy 1, in-flight 1 -> all outputs zero immediately, first post-reset request addr RESET_PC.
